// File: rtl/sram_tile_reader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aura_pkg : shared types for the K/V tile read engine             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package aura_pkg;

  localparam int AURA_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    FLUSH  = 2'd3
  } tile_rd_state_t;

  typedef struct packed {
    logic [AURA_WORD_W-1:0] data;
    logic                   pass_last;
    logic                   last;
  } tile_rd_beat_t;

endpackage
`default_nettype wire

// File: rtl/sram_tile_reader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sram_tile_reader_if : command, SRAM read port and output stream  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface sram_tile_reader_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int REP_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_base;
  logic [AW:0]      cmd_len;
  logic [REP_W-1:0] cmd_reps;

  logic             re;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_pass_last;
  logic             out_last;
  logic             done;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_base, cmd_len, cmd_reps, rdata, out_ready,
    output cmd_ready, re, raddr, out_valid, out_data, out_pass_last, out_last, done, busy
  );

  modport master (
    output cmd_valid, cmd_base, cmd_len, cmd_reps, rdata, out_ready,
    input  cmd_ready, re, raddr, out_valid, out_data, out_pass_last, out_last, done, busy
  );

endinterface
`default_nettype wire

// File: rtl/sram_tile_reader_skid_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stream_skid_buf : 2-entry FIFO with registered occupancy         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module stream_skid_buf #(
  parameter int PAYLOAD_W = 34
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [PAYLOAD_W-1:0] i_data,
  input  logic                 i_pop,
  output logic                 o_valid,
  output logic [PAYLOAD_W-1:0] o_data,
  output logic [1:0]           o_count
);

  logic [PAYLOAD_W-1:0] mem_q [2];
  logic [PAYLOAD_W-1:0] mem_d [2];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 w_push;
  logic                 w_pop;

  always_comb begin
    w_pop    = i_pop && (count_q != 2'd0);
    // A push while full is dropped; the producer gates on o_count.
    w_push   = i_push && (count_q != 2'd2);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_valid = (count_q != 2'd0);
  assign o_data  = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/sram_tile_reader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sram_tile_reader : replays a wrapped SRAM tile as a beat stream  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sram_tile_reader
  import aura_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int REP_W = 8
) (
  input logic               clk,
  input logic               rst,
  sram_tile_reader_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = WIDTH + 2;

  tile_rd_state_t   state_q, state_d;
  logic [AW-1:0]    base_q, base_d;
  logic [LW-1:0]    len_q, len_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [AW-1:0]    offset_q, offset_d;
  logic [REP_W-1:0] pass_q, pass_d;
  logic             done_q, done_d;

  logic [LW-1:0]    w_addr_sum;
  logic [LW-1:0]    w_addr_wrap;
  logic [AW-1:0]    w_raddr;
  logic             w_re;
  logic             w_pass_last;
  logic             w_last;
  logic             w_cmd_ready;
  logic             w_accept;
  logic             w_pop;
  logic             w_fifo_valid;
  logic [PW-1:0]    w_fifo_head;
  logic [1:0]       w_fifo_count;

  always_comb begin
    // base < DEPTH and offset < DEPTH, so one conditional subtract suffices.
    w_addr_sum  = {1'b0, base_q} + {1'b0, offset_q};
    w_addr_wrap = (w_addr_sum >= LW'(DEPTH)) ? (w_addr_sum - LW'(DEPTH)) : w_addr_sum;
    w_raddr     = w_addr_wrap[AW-1:0];
    w_re        = (state_q == STREAM) && (w_fifo_count < 2'd2);
    w_pass_last = ({1'b0, offset_q} == (len_q - LW'(1)));
    w_last      = w_pass_last && (pass_q == (reps_q - REP_W'(1)));
    // FLUSH is the done cycle of an empty command and may take the next one.
    w_cmd_ready = (state_q == IDLE) || (state_q == FLUSH);
    w_accept    = bus.cmd_valid && w_cmd_ready;
    w_pop       = w_fifo_valid && bus.out_ready;
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    reps_d   = reps_q;
    offset_d = offset_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE, FLUSH: begin
        state_d = IDLE;
        if (w_accept) begin
          base_d   = bus.cmd_base;
          len_d    = bus.cmd_len;
          reps_d   = bus.cmd_reps;
          offset_d = '0;
          pass_d   = '0;
          if ((bus.cmd_len == '0) || (bus.cmd_reps == '0)) begin
            state_d = FLUSH;
            done_d  = 1'b1;
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (w_re) begin
          if (w_pass_last) begin
            offset_d = '0;
            pass_d   = pass_q + REP_W'(1);
            if (w_last) begin
              state_d = DRAIN;
            end
          end else begin
            offset_d = offset_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (w_pop && w_fifo_head[0]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      reps_q   <= '0;
      offset_q <= '0;
      pass_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      reps_q   <= reps_d;
      offset_q <= offset_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
    end
  end

  stream_skid_buf #(
    .PAYLOAD_W (PW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_re),
    .i_data  ({bus.rdata, w_pass_last, w_last}),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count)
  );

  assign bus.cmd_ready     = w_cmd_ready;
  assign bus.re            = w_re;
  assign bus.raddr         = w_raddr;
  assign bus.out_valid     = w_fifo_valid;
  assign bus.out_data      = w_fifo_head[PW-1:2];
  assign bus.out_pass_last = w_fifo_head[1];
  assign bus.out_last      = w_fifo_head[0];
  assign bus.done          = done_q;
  assign bus.busy          = (state_q != IDLE);

`ifdef GEN_ASSERT
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      assert (bus.cmd_len <= LW'(DEPTH));
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/sram_tile_reader.md
# sram_tile_reader

Read-side engine for the single-write-port scratchpad SRAM holding K/V tiles. It accepts a tile command (base, length, repetitions), issues sequential reads with address wrap-around, and presents the words as a valid/ready stream to the attention datapath. Each tile can be replayed once per Q row without the writer re-loading it. It sits between the scratchpad's read port and the dot-product/softmax pipeline.

## Interface
- WIDTH, 32: data word width.
- DEPTH, 32: SRAM entries; any value ≥ 2, not required to be a power of two.
- REP_W, 8: width of the repetition count.
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle, command accepted when both cmd_valid and cmd_ready are high.
- cmd_base  in  $clog2(DEPTH)  first entry address.
- cmd_len  in  $clog2(DEPTH)+1  words per pass, 0..DEPTH.
- cmd_reps  in  REP_W  number of passes.
- re  out  1  SRAM read enable.
- raddr  out  $clog2(DEPTH)  SRAM read address.
- rdata  in  WIDTH  SRAM read data, combinational from raddr in the same cycle.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  stream word.
- out_pass_last  out  1  word is the last of a pass.
- out_last  out  1  word is the last of the command.
- done  out  1  one-cycle pulse when the command completes.
- busy  out  1  command in progress.

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch base/len/reps and clear offset and pass counters. If len==0 or reps==0, go to FLUSH. Otherwise go to STREAM.
  - STREAM: issue reads.
  - DRAIN: all reads issued; wait for the buffer to empty.
  - FLUSH: pulse done, go to IDLE, emit no words.
- Issue rule in STREAM: re=1 exactly when the output buffer holds fewer than 2 entries.
  - rdata is captured into the buffer at that edge, tagged with pass_last and last.
- Address: raddr = base+offset, minus DEPTH if ≥ DEPTH. The offset runs 0..len-1 and wraps to 0 at the end of each pass.
  - The pass counter increments when the offset wraps.
  - After the last read of the last pass, go to DRAIN.
- Output buffer: a 2-entry FIFO. out_valid = not empty, and head fields drive out_data, out_pass_last and out_last.
  - Push and pop may occur in the same cycle.
  - out_data is held stable while out_valid && !out_ready.
- Completion: done=1 in the cycle after the handshake of the word with out_last. That same cycle the FSM is back in IDLE with cmd_ready=1.
  - From FLUSH, done=1 in the cycle after accept.
- busy = state != IDLE.
- cmd_len > DEPTH is illegal. An assertion under GEN_ASSERT flags it; hardware behaviour is then undefined.
- Reset mid-command: the command is abandoned, the buffer is flushed, and no done pulse is produced.

## Timing
- Reset values: cmd_ready=1 from the first cycle after reset; re=0, raddr=0, out_valid=0, out_data=0, out_pass_last=0, out_last=0, done=0, busy=0.
- Accept at cycle T: first re at T+1 with raddr=base, first out_valid at T+2.
- With out_ready held high, throughput is 1 word per cycle with no bubbles across pass boundaries.
- There is no combinational path from out_ready to re or raddr; re depends only on registered buffer occupancy.
- A command of L×R words with no backpressure: last handshake at T+1+L·R, done at T+2+L·R.
- A command may be presented during the done cycle and is accepted in that cycle.

## Structure
- Shared package aura_pkg holds the state enum tile_rd_state_t (IDLE, STREAM, DRAIN, FLUSH) and a packed struct tile_rd_beat_t {data, pass_last, last}.
- The 2-entry FIFO is a separate sub-module, stream_skid_buf, parameterised by payload width and reused elsewhere in the datapath.
- Counter and wrap arithmetic stays in sram_tile_reader.

## Test plan
- base=0, len=4, reps=1, SRAM[i]=i+100, out_ready=1:
  - Words 100..103 at T+2..T+5.
  - out_pass_last and out_last on 103.
  - done at T+6.
- base=30, len=4, reps=2, DEPTH=32:
  - raddr sequence 30,31,0,1,30,31,0,1.
  - out_pass_last on beats 4 and 8; out_last only on beat 8.
- Backpressure case: out_ready toggled 1/0 every cycle, then held 0 for 5 cycles.
  - No word lost or duplicated, and out_data is stable while stalled.
  - re stays low once the buffer holds 2 words.
- len=0, or reps=0 with len=5:
  - No re and no out_valid.
  - done at T+1, cmd_ready back high at T+1.
- reset asserted in the middle of a reps=3 command: the next cycle shows all outputs at their reset values, and a new command afterwards streams correctly.
- Back-to-back commands: a second cmd_valid held high is accepted in the done cycle of the first, and its first word appears 2 cycles later.
